// File: rtl/sram_confreg.sv
// rtl/sram_confreg.sv - config/status register block on the CPU data-SRAM port
//
// Purpose: answers data-SRAM style accesses (en/we/addr/wdata -> rdata one cycle
// later) inside a 64 KiB window and exposes LED/NUM registers, a synchronized
// switch input, a free-running timer and a byte console TX FIFO.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   data_sram_en/we/addr/wdata access request; we==0 is a read
//   data_sram_rdata            registered read data (one-cycle latency)
//   switch_i                   asynchronous board switches
//   led_o, num_o               LED and seven-segment registers
//   tx_valid, tx_data, tx_ready console byte stream out of the FIFO
module sram_confreg #(
  parameter logic [31:0] ADDR_BASE  = 32'h1faf_0000,
  parameter logic [31:0] ADDR_MASK  = 32'hffff_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_i,
  output logic [15:0] led_o,
  output logic [31:0] num_o,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [15:0] OFF_LED    = 16'h0000;
  localparam logic [15:0] OFF_NUM    = 16'h0004;
  localparam logic [15:0] OFF_SWITCH = 16'h0008;
  localparam logic [15:0] OFF_TIMER  = 16'h000c;
  localparam logic [15:0] OFF_TXDATA = 16'h0010;
  localparam logic [15:0] OFF_STATUS = 16'h0014;

  function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? wd[8*i +: 8] : cur[8*i +: 8];
    end
    return res;
  endfunction

  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [31:0] timer_q, timer_d;
  logic [15:0] sw_meta_q, sw_sync_q;
  logic        ovf_q, ovf_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]  mem_q [FIFO_DEPTH];

  logic        hit, wr_acc, rd_acc;
  logic [15:0] off;
  logic        fifo_empty, fifo_full, push_req, push_ok, pop;
  logic [31:0] status, rd_val;

  // Decode. Out-of-window reads still complete (returning 0) so rdata
  // behaves the same as the data RAM for any read the CPU issues.
  assign hit    = data_sram_en && ((data_sram_addr & ADDR_MASK) == ADDR_BASE);
  assign off    = data_sram_addr[15:0] & 16'hfffc;
  assign wr_acc = hit && (data_sram_we != 4'b0000);
  assign rd_acc = data_sram_en && (data_sram_we == 4'b0000);

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign push_req   = wr_acc && (off == OFF_TXDATA) && data_sram_we[0];
  assign pop        = !fifo_empty && tx_ready;
  // A push into a full FIFO is accepted only when a pop frees a slot that cycle.
  assign push_ok    = push_req && (!fifo_full || pop);

  always_comb begin
    status          = '0;
    status[0]       = fifo_empty;
    status[1]       = fifo_full;
    status[2]       = ovf_q;
    status[8 +: CW] = count_q;
  end

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_LED:    rd_val = {16'h0000, led_q};
      OFF_NUM:    rd_val = num_q;
      OFF_SWITCH: rd_val = {16'h0000, sw_sync_q};
      OFF_TIMER:  rd_val = timer_q;
      OFF_STATUS: rd_val = status;
      default:    rd_val = '0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) begin
      rdata_d = hit ? rd_val : 32'h0;
    end

    led_d = led_q;
    if (wr_acc && (off == OFF_LED)) begin
      led_d[7:0]  = data_sram_we[0] ? data_sram_wdata[7:0]  : led_q[7:0];
      led_d[15:8] = data_sram_we[1] ? data_sram_wdata[15:8] : led_q[15:8];
    end

    num_d = num_q;
    if (wr_acc && (off == OFF_NUM)) begin
      num_d = lane_merge(num_q, data_sram_wdata, data_sram_we);
    end

    // A timer write replaces the increment for that cycle.
    timer_d = timer_q + 32'd1;
    if (wr_acc && (off == OFF_TIMER)) begin
      timer_d = lane_merge(timer_q, data_sram_wdata, data_sram_we);
    end

    ovf_d = ovf_q;
    if (wr_acc && (off == OFF_STATUS) && data_sram_we[0] && data_sram_wdata[2]) begin
      ovf_d = 1'b0;
    end
    if (push_req && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end

    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q   <= '0;
      led_q     <= '0;
      num_q     <= '0;
      timer_q   <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      ovf_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      num_q     <= num_d;
      timer_q   <= timer_d;
      sw_meta_q <= switch_i;
      sw_sync_q <= sw_meta_q;
      ovf_q     <= ovf_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= data_sram_wdata[7:0];
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led_o           = led_q;
  assign num_o           = num_q;
  assign tx_valid        = !fifo_empty;
  assign tx_data         = mem_q[rptr_q];

endmodule
